// File: rtl/utils_pkg.sv
// Shared types for the PE array job sequencer: FSM state encoding and job constants.
package utils_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN0,
    ST_SWAP,
    ST_RUN1,
    ST_RESTORE,
    ST_DRAIN,
    ST_DONE
  } pe_ctrl_state_t;

  // One pop per slot swap plus one to restore slot 0.
  localparam int unsigned NUM_POPS_PER_JOB = 2;

endpackage

// File: rtl/pe_array_ctrl_if.sv
// Control, weight, activation and pop signals between the sequencer and its buffers/array.
// PE_ARRAY_CTRL_WGT_REUSE_EN adds i_reuse_wgt.
interface pe_array_ctrl_if #(
  parameter int ID_WIDTH      = 6,
  parameter int IN_DATA_WIDTH = 8,
  parameter int VEC_WIDTH     = 10
);
  logic                     i_start;
  logic [VEC_WIDTH-1:0]     i_num_vec;
`ifdef PE_ARRAY_CTRL_WGT_REUSE_EN
  logic                     i_reuse_wgt;
`endif
  logic                     o_busy;
  logic                     o_done;
  logic                     i_wgt_vld;
  logic [IN_DATA_WIDTH-1:0] i_wgt_data;
  logic                     o_wgt_rdy;
  logic                     o_load_vld;
  logic [ID_WIDTH-1:0]      o_load_id;
  logic [IN_DATA_WIDTH-1:0] o_load_data;
  logic                     i_act_vld;
  logic [IN_DATA_WIDTH-1:0] i_act_data;
  logic                     o_act_rdy;
  logic [IN_DATA_WIDTH-1:0] o_left_data;
  logic                     o_left_vld;
  logic                     o_pop_vld;
  logic                     i_pop_ret;

  modport slave (
`ifdef PE_ARRAY_CTRL_WGT_REUSE_EN
    input  i_reuse_wgt,
`endif
    input  i_start, i_num_vec, i_wgt_vld, i_wgt_data, i_act_vld, i_act_data, i_pop_ret,
    output o_busy, o_done, o_wgt_rdy, o_load_vld, o_load_id, o_load_data,
    output o_act_rdy, o_left_data, o_left_vld, o_pop_vld
  );

  modport master (
`ifdef PE_ARRAY_CTRL_WGT_REUSE_EN
    output i_reuse_wgt,
`endif
    output i_start, i_num_vec, i_wgt_vld, i_wgt_data, i_act_vld, i_act_data, i_pop_ret,
    input  o_busy, o_done, o_wgt_rdy, o_load_vld, o_load_id, o_load_data,
    input  o_act_rdy, o_left_data, o_left_vld, o_pop_vld
  );

endinterface

// File: rtl/pe_array_ctrl_wgt_loader.sv
// Converts the weight stream into load-bus writes, two beats per PE (slot 0 then slot 1).
module pe_wgt_loader #(
  parameter int ID_WIDTH      = 6,
  parameter int IN_DATA_WIDTH = 8,
  parameter int NUM_PE        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     wgt_vld,
  input  logic [IN_DATA_WIDTH-1:0] wgt_data,
  output logic                     wgt_rdy,
  output logic                     load_vld,
  output logic [ID_WIDTH-1:0]      load_id,
  output logic [IN_DATA_WIDTH-1:0] load_data,
  output logic                     last_beat
);
  // One extra bit over the PE id holds the slot index in its LSB.
  localparam int CW = ID_WIDTH + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(2 * NUM_PE - 1);

  logic [CW-1:0]            beat_cnt_q, beat_cnt_d;
  logic                     load_vld_q, load_vld_d;
  logic [ID_WIDTH-1:0]      load_id_q, load_id_d;
  logic [IN_DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic                     hs;

  assign wgt_rdy   = en;
  assign hs        = en & wgt_vld;
  assign last_beat = hs && (beat_cnt_q == LAST_BEAT);

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    load_vld_d  = hs;
    load_id_d   = '0;
    load_data_d = '0;
    if (hs) begin
      beat_cnt_d  = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;
      load_id_d   = beat_cnt_q[ID_WIDTH:1];
      load_data_d = wgt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      load_vld_q  <= 1'b0;
      load_id_q   <= '0;
      load_data_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      load_vld_q  <= load_vld_d;
      load_id_q   <= load_id_d;
      load_data_q <= load_data_d;
    end
  end

  assign load_vld  = load_vld_q;
  assign load_id   = load_id_q;
  assign load_data = load_data_q;

endmodule

// File: rtl/pe_array_ctrl.sv
// Job sequencer for a dual-weight PE column chain: load weights, run slot 0, pop, run slot 1, pop, drain.
// PE_ARRAY_CTRL_WGT_REUSE_EN adds i_reuse_wgt to skip the weight load on a job.
module pe_array_ctrl
  import utils_pkg::*;
#(
  parameter int ID_WIDTH      = 6,
  parameter int IN_DATA_WIDTH = 8,
  parameter int NUM_PE        = 16,
  parameter int VEC_WIDTH     = 10,
  parameter int DRAIN_CYCLES  = 8
) (
  input logic          clk,
  input logic          rst,
  pe_array_ctrl_if.slave bus
);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  pe_ctrl_state_t           state_q, state_d;
  logic [VEC_WIDTH-1:0]     num_vec_q, num_vec_d;
  logic [VEC_WIDTH-1:0]     vec_cnt_q, vec_cnt_d;
  logic [IN_DATA_WIDTH-1:0] left_data_q, left_data_d;
  logic                     left_vld_q, left_vld_d;
  logic [1:0]               ret_cnt_q, ret_cnt_d;
  logic [DCW-1:0]           drain_cnt_q, drain_cnt_d;
  logic                     wgt_en, act_rdy, pop_vld, done, last_beat, act_hs, skip_load;

  pe_wgt_loader #(
    .ID_WIDTH(ID_WIDTH), .IN_DATA_WIDTH(IN_DATA_WIDTH), .NUM_PE(NUM_PE)
  ) u_loader (
    .clk(clk), .rst(rst), .en(wgt_en),
    .wgt_vld(bus.i_wgt_vld), .wgt_data(bus.i_wgt_data), .wgt_rdy(bus.o_wgt_rdy),
    .load_vld(bus.o_load_vld), .load_id(bus.o_load_id), .load_data(bus.o_load_data),
    .last_beat(last_beat)
  );

`ifdef PE_ARRAY_CTRL_WGT_REUSE_EN
  assign skip_load = bus.i_reuse_wgt;
`else
  assign skip_load = 1'b0;
`endif

  assign act_hs = act_rdy & bus.i_act_vld;

  always_comb begin
    state_d     = state_q;
    num_vec_d   = num_vec_q;
    vec_cnt_d   = vec_cnt_q;
    left_data_d = '0;
    left_vld_d  = 1'b0;
    ret_cnt_d   = ret_cnt_q;
    drain_cnt_d = drain_cnt_q;
    wgt_en      = 1'b0;
    act_rdy     = 1'b0;
    pop_vld     = 1'b0;
    done        = 1'b0;

    // Returns may arrive before DRAIN when the chain is short, so count all job long.
    if (state_q != ST_IDLE && bus.i_pop_ret && ret_cnt_q != 2'b11)
      ret_cnt_d = ret_cnt_q + 2'd1;

    case (state_q)
      ST_IDLE: begin
        ret_cnt_d   = '0;
        drain_cnt_d = '0;
        vec_cnt_d   = '0;
        if (bus.i_start) begin
          num_vec_d = bus.i_num_vec;
          if (skip_load) state_d = (bus.i_num_vec == '0) ? ST_SWAP : ST_RUN0;
          else           state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        wgt_en = 1'b1;
        if (last_beat) state_d = (num_vec_q == '0) ? ST_SWAP : ST_RUN0;
      end
      ST_RUN0, ST_RUN1: begin
        act_rdy = 1'b1;
        if (act_hs) begin
          left_data_d = bus.i_act_data;
          left_vld_d  = 1'b1;
          if (vec_cnt_q == num_vec_q - 1'b1) begin
            vec_cnt_d = '0;
            state_d   = (state_q == ST_RUN0) ? ST_SWAP : ST_RESTORE;
          end else begin
            vec_cnt_d = vec_cnt_q + 1'b1;
          end
        end
      end
      ST_SWAP: begin
        pop_vld = 1'b1;
        state_d = (num_vec_q == '0) ? ST_RESTORE : ST_RUN1;
      end
      ST_RESTORE: begin
        pop_vld = 1'b1;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (ret_cnt_d >= 2'(NUM_POPS_PER_JOB)) begin
          if (drain_cnt_q == DCW'(DRAIN_CYCLES - 1)) begin
            drain_cnt_d = '0;
            state_d     = ST_DONE;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      num_vec_q   <= '0;
      vec_cnt_q   <= '0;
      left_data_q <= '0;
      left_vld_q  <= 1'b0;
      ret_cnt_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      num_vec_q   <= num_vec_d;
      vec_cnt_q   <= vec_cnt_d;
      left_data_q <= left_data_d;
      left_vld_q  <= left_vld_d;
      ret_cnt_q   <= ret_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign bus.o_busy      = (state_q != ST_IDLE);
  assign bus.o_done      = done;
  assign bus.o_act_rdy   = act_rdy;
  assign bus.o_pop_vld   = pop_vld;
  assign bus.o_left_data = left_data_q;
  assign bus.o_left_vld  = left_vld_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Randomized job-level bench for pe_array_ctrl; the model tracks beats, pops and returns per job.
// Exercises i_reuse_wgt when PE_ARRAY_CTRL_WGT_REUSE_EN is defined.
module tb_pe_array_ctrl;
  localparam int ID_W  = 6;
  localparam int DW    = 8;
  localparam int NPE   = 4;
  localparam int VW    = 10;
  localparam int DRAIN = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_array_ctrl_if #(.ID_WIDTH(ID_W), .IN_DATA_WIDTH(DW), .VEC_WIDTH(VW)) bus ();

  pe_array_ctrl #(
    .ID_WIDTH(ID_W), .IN_DATA_WIDTH(DW), .NUM_PE(NPE), .VEC_WIDTH(VW), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_start    = 1'b0;
    bus.i_num_vec  = '0;
    bus.i_wgt_vld  = 1'b0;
    bus.i_wgt_data = '0;
    bus.i_act_vld  = 1'b0;
    bus.i_act_data = '0;
    bus.i_pop_ret  = 1'b0;
`ifdef PE_ARRAY_CTRL_WGT_REUSE_EN
    bus.i_reuse_wgt = 1'b0;
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      32'(bus.o_busy),      32'd0);
    chk({tag, "_done"},      32'(bus.o_done),      32'd0);
    chk({tag, "_wgt_rdy"},   32'(bus.o_wgt_rdy),   32'd0);
    chk({tag, "_load_vld"},  32'(bus.o_load_vld),  32'd0);
    chk({tag, "_load_id"},   32'(bus.o_load_id),   32'd0);
    chk({tag, "_load_data"}, 32'(bus.o_load_data), 32'd0);
    chk({tag, "_act_rdy"},   32'(bus.o_act_rdy),   32'd0);
    chk({tag, "_left_vld"},  32'(bus.o_left_vld),  32'd0);
    chk({tag, "_left_data"}, 32'(bus.o_left_data), 32'd0);
    chk({tag, "_pop_vld"},   32'(bus.o_pop_vld),   32'd0);
  endtask

  // mode 0: random valids/data; 1: continuous, weights 1.. and acts 5.. / 9..; 2: as 1 but act valid toggles.
  task automatic run_job(input int nv, input int mode, input bit reuse, input bit abort_run1);
    int wcnt = 0, a0 = 0, a1 = 0, pops = 0, rets = 0, cyc = 0, done_cyc = -1, last_ret = 0;
    int ret_at[$];
    bit exp_lv = 0, exp_av = 0, fin = 0;
    bit loading, run0, run1, pop_now, wv, av;
    logic [ID_W-1:0] exp_lid = '0;
    logic [DW-1:0] exp_ld = '0, exp_ad = '0, wdat, adat;

    @(negedge clk);
    chk_all_zero("pre_start");
    bus.i_start   = 1'b1;
    bus.i_num_vec = VW'(nv);
`ifdef PE_ARRAY_CTRL_WGT_REUSE_EN
    bus.i_reuse_wgt = reuse;
`endif
    @(negedge clk);
    bus.i_start = 1'b0;

    while (!fin) begin
      cyc++;
      loading = !reuse && (wcnt < 2 * NPE);
      run0    = !loading && (a0 < nv);
      pop_now = !loading && ((pops == 0 && a0 >= nv) || (pops == 1 && a1 >= nv));
      run1    = (pops == 1) && (a1 < nv);

      chk("busy",     32'(bus.o_busy),     32'd1);
      chk("wgt_rdy",  32'(bus.o_wgt_rdy),  32'(loading));
      chk("act_rdy",  32'(bus.o_act_rdy),  32'(run0 || run1));
      chk("pop_vld",  32'(bus.o_pop_vld),  32'(pop_now));
      chk("done",     32'(bus.o_done),     32'(cyc == done_cyc));
      chk("load_vld", 32'(bus.o_load_vld), 32'(exp_lv));
      if (exp_lv) begin
        chk("load_id",   32'(bus.o_load_id),   32'(exp_lid));
        chk("load_data", 32'(bus.o_load_data), 32'(exp_ld));
      end
      chk("left_vld",  32'(bus.o_left_vld),  32'(exp_av));
      chk("left_data", 32'(bus.o_left_data), 32'(exp_ad));

      if (cyc == done_cyc) begin
        idle_inputs();
        @(negedge clk);
        chk("post_done_busy", 32'(bus.o_busy), 32'd0);
        chk("post_done_done", 32'(bus.o_done), 32'd0);
        fin = 1;
      end else if (abort_run1 && run1 && a1 >= 1) begin
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("abort");
        rst = 1'b0;
        fin = 1;
      end else if (cyc > 3000) begin
        chk("job_timeout", 32'd1, 32'd0);
        idle_inputs();
        fin = 1;
      end else begin
        wv   = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        av   = (mode == 0) ? 1'($urandom_range(0, 1)) : (mode == 2) ? 1'(cyc % 2) : 1'b1;
        wdat = (mode == 0) ? DW'($urandom) : DW'(wcnt + 1);
        adat = (mode == 0) ? DW'($urandom) : (pops == 0) ? DW'(5 + a0) : DW'(9 + a1);
        bus.i_wgt_vld  = wv;
        bus.i_wgt_data = wdat;
        bus.i_act_vld  = av;
        bus.i_act_data = adat;
        // A start while busy must be ignored.
        bus.i_start    = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.i_pop_ret  = 1'b0;
        if (ret_at.size() > 0 && ret_at[0] == cyc) begin
          void'(ret_at.pop_front());
          bus.i_pop_ret = 1'b1;
          rets++;
          last_ret = cyc;
          if (rets == 2) done_cyc = cyc + DRAIN;
        end

        exp_lv = loading && wv;
        if (exp_lv) begin
          exp_lid = ID_W'(wcnt / 2);
          exp_ld  = wdat;
          wcnt++;
        end
        exp_av = (run0 || run1) && av;
        exp_ad = exp_av ? adat : '0;
        if (exp_av) begin
          if (run0) a0++;
          else      a1++;
        end
        if (pop_now) begin
          int t;
          pops++;
          t = cyc + $urandom_range(1, 6);
          if (ret_at.size() > 0 && t <= ret_at[$]) t = ret_at[$] + 1;
          if (t <= last_ret) t = last_ret + 1;
          ret_at.push_back(t);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("idle");

    // Stray pop return while idle must not count toward the next job.
    bus.i_pop_ret = 1'b1;
    @(negedge clk);
    bus.i_pop_ret = 1'b0;

    run_job(3, 1, 1'b0, 1'b0);
    run_job(3, 2, 1'b0, 1'b0);
    run_job(0, 0, 1'b0, 1'b0);
    run_job(4, 0, 1'b0, 1'b1);
    run_job(3, 1, 1'b0, 1'b0);
    for (int j = 0; j < 6; j++) run_job(int'($urandom_range(0, 5)), 0, 1'b0, 1'b0);
`ifdef PE_ARRAY_CTRL_WGT_REUSE_EN
    run_job(3, 0, 1'b1, 1'b0);
    run_job(0, 0, 1'b1, 1'b0);
    run_job(2, 1, 1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
